uart_frame_scheduler: RTL and testbench

UART_FRAME_SCHEDULER -- requirements
Module: uart_frame_scheduler

---
 rtl/uart_frame_scheduler.sv | 148 ++++++++++++++
 tb/tb_uart_frame_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_scheduler.sv
// Serialises a snapshot of the local tank/bullet state into a 9-byte UART frame
// (header, 7 payload bytes, XOR checksum) once per accepted frame tick.
module uart_frame_scheduler #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       link_en,
  input  logic       frame_tick,
  input  logic [9:0] xpos_tank,
  input  logic [9:0] ypos_tank,
  input  logic [9:0] xpos_bullet,
  input  logic [9:0] ypos_bullet,
  input  logic [1:0] direction_tank,
  input  logic [2:0] direction_bullet,
  input  logic       tank_hit,
  input  logic       obstacle_hit,
  input  logic [7:0] hp,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] overrun_cnt
);

  typedef enum logic [1:0] {IDLE, SNAP, SEND, WAIT_DONE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] byte_idx_reg, byte_idx_next;
  logic [7:0] checksum_reg, checksum_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic [7:0] overrun_reg, overrun_next;
  logic       frame_done_reg, frame_done_next;
  logic       snap_load;

  logic [9:0] snap_xpos_tank_reg, snap_ypos_tank_reg;
  logic [9:0] snap_xpos_bullet_reg, snap_ypos_bullet_reg;
  logic [1:0] snap_dir_tank_reg;
  logic [2:0] snap_dir_bullet_reg;
  logic       snap_tank_hit_reg, snap_obstacle_hit_reg;
  logic [7:0] snap_hp_reg;

  logic [7:0] frame_bytes [8];

  // Payload bytes are built only from the snapshot so late input changes never leak in.
  assign frame_bytes[0] = HEADER;
  assign frame_bytes[1] = snap_xpos_tank_reg[7:0];
  assign frame_bytes[2] = snap_ypos_tank_reg[7:0];
  assign frame_bytes[3] = {snap_xpos_tank_reg[9:8], snap_ypos_tank_reg[9:8],
                           snap_dir_tank_reg, snap_tank_hit_reg, snap_obstacle_hit_reg};
  assign frame_bytes[4] = snap_xpos_bullet_reg[7:0];
  assign frame_bytes[5] = snap_ypos_bullet_reg[7:0];
  assign frame_bytes[6] = {snap_xpos_bullet_reg[9:8], snap_ypos_bullet_reg[9:8],
                           1'b0, snap_dir_bullet_reg};
  assign frame_bytes[7] = snap_hp_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg             <= IDLE;
      byte_idx_reg          <= 4'd0;
      checksum_reg          <= 8'h00;
      tx_data_reg           <= 8'h00;
      overrun_reg           <= 8'h00;
      frame_done_reg        <= 1'b0;
      snap_xpos_tank_reg    <= 10'd0;
      snap_ypos_tank_reg    <= 10'd0;
      snap_xpos_bullet_reg  <= 10'd0;
      snap_ypos_bullet_reg  <= 10'd0;
      snap_dir_tank_reg     <= 2'd0;
      snap_dir_bullet_reg   <= 3'd0;
      snap_tank_hit_reg     <= 1'b0;
      snap_obstacle_hit_reg <= 1'b0;
      snap_hp_reg           <= 8'h00;
    end else begin
      state_reg      <= state_next;
      byte_idx_reg   <= byte_idx_next;
      checksum_reg   <= checksum_next;
      tx_data_reg    <= tx_data_next;
      overrun_reg    <= overrun_next;
      frame_done_reg <= frame_done_next;
      if (snap_load) begin
        snap_xpos_tank_reg    <= xpos_tank;
        snap_ypos_tank_reg    <= ypos_tank;
        snap_xpos_bullet_reg  <= xpos_bullet;
        snap_ypos_bullet_reg  <= ypos_bullet;
        snap_dir_tank_reg     <= direction_tank;
        snap_dir_bullet_reg   <= direction_bullet;
        snap_tank_hit_reg     <= tank_hit;
        snap_obstacle_hit_reg <= obstacle_hit;
        snap_hp_reg           <= hp;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    byte_idx_next   = byte_idx_reg;
    checksum_next   = checksum_reg;
    tx_data_next    = tx_data_reg;
    overrun_next    = overrun_reg;
    frame_done_next = 1'b0;
    snap_load       = 1'b0;

    // Any enabled tick outside IDLE is an overrun, including one coinciding with the last tx_done.
    if (frame_tick && link_en && (state_reg != IDLE) && (overrun_reg != 8'hFF))
      overrun_next = overrun_reg + 8'd1;

    case (state_reg)
      IDLE: begin
        if (frame_tick && link_en)
          state_next = SNAP;
      end
      SNAP: begin
        snap_load     = 1'b1;
        byte_idx_next = 4'd0;
        checksum_next = 8'h00;
        tx_data_next  = HEADER;
        state_next    = SEND;
      end
      SEND: begin
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (byte_idx_reg < 4'd8) begin
            checksum_next = checksum_reg ^ tx_data_reg;
            byte_idx_next = byte_idx_reg + 4'd1;
            tx_data_next  = (byte_idx_reg == 4'd7) ? (checksum_reg ^ tx_data_reg)
                                                   : frame_bytes[3'(byte_idx_reg[2:0] + 3'd1)];
            state_next    = SEND;
          end else begin
            frame_done_next = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_data     = tx_data_reg;
  assign tx_start    = (state_reg == SEND);
  assign busy        = (state_reg != IDLE);
  assign frame_done  = frame_done_reg;
  assign overrun_cnt = overrun_reg;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler: a transaction-level frame model checks
// every cycle, and literal golden bytes/counts pin the model.
module tb_uart_frame_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       link_en = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] xpos_tank = '0, ypos_tank = '0, xpos_bullet = '0, ypos_bullet = '0;
  logic [1:0] direction_tank = '0;
  logic [2:0] direction_bullet = '0;
  logic       tank_hit = 1'b0, obstacle_hit = 1'b0;
  logic [7:0] hp = '0;
  logic       tx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start, busy, frame_done;
  logic [7:0] overrun_cnt;

  uart_frame_scheduler #(.HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .link_en(link_en), .frame_tick(frame_tick),
    .xpos_tank(xpos_tank), .ypos_tank(ypos_tank),
    .xpos_bullet(xpos_bullet), .ypos_bullet(ypos_bullet),
    .direction_tank(direction_tank), .direction_bullet(direction_bullet),
    .tank_hit(tank_hit), .obstacle_hit(obstacle_hit), .hp(hp),
    .tx_done(tx_done), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .frame_done(frame_done), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  logic [7:0] seen [$];
  logic [7:0] gold [9];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Transaction-level model: a frame is a list of 9 bytes captured one cycle after
  // acceptance; each byte start is scheduled one cycle after the previous byte's done.
  bit         busy_m = 1'b0;
  int         ovr_m = 0;
  int         snap_at = -1, start_at = -1, done_at = -1;
  bit         outstanding = 1'b0;
  int         idx = 0;
  logic [7:0] fb [9];

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("busy", {31'd0, busy}, {31'd0, busy_m});
        check("tx_start", {31'd0, tx_start}, {31'd0, cyc == start_at});
        check("frame_done", {31'd0, frame_done}, {31'd0, cyc == done_at});
        check("overrun_cnt", {24'd0, overrun_cnt}, ovr_m);
        if (cyc == start_at || outstanding)
          check("tx_data", {24'd0, tx_data}, {24'd0, fb[idx]});
        if (tx_start) seen.push_back(tx_data);
      end
      if (rst) begin
        busy_m = 1'b0; ovr_m = 0; outstanding = 1'b0; idx = 0;
        snap_at = -1; start_at = -1; done_at = -1;
      end else begin
        if (frame_tick && link_en) begin
          if (busy_m) begin
            if (ovr_m < 255) ovr_m++;
          end else begin
            busy_m = 1'b1; snap_at = cyc + 1; start_at = cyc + 2;
          end
        end
        if (cyc == snap_at) begin
          fb[0] = 8'hA5;
          fb[1] = xpos_tank[7:0];
          fb[2] = ypos_tank[7:0];
          fb[3] = {xpos_tank[9:8], ypos_tank[9:8], direction_tank, tank_hit, obstacle_hit};
          fb[4] = xpos_bullet[7:0];
          fb[5] = ypos_bullet[7:0];
          fb[6] = {xpos_bullet[9:8], ypos_bullet[9:8], 1'b0, direction_bullet};
          fb[7] = hp;
          fb[8] = 8'h00;
          for (int i = 0; i < 8; i++) fb[8] = fb[8] ^ fb[i];
          idx = 0;
        end
        if (outstanding && tx_done) begin
          outstanding = 1'b0;
          if (idx == 8) begin
            busy_m = 1'b0; done_at = cyc + 1;
          end else begin
            idx++; start_at = cyc + 1;
          end
        end
        if (cyc == start_at) outstanding = 1'b1;
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    tx_done = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!tx_start && n < 60) begin
      step();
      n++;
    end
    if (!tx_start) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_start: tx_start=0 after 60 cycles, required 1");
    end
  endtask

  // Acts as the UART: tx_done arrives lat cycles after the start; ticks on k in [lo,hi].
  task automatic serve_byte(input int lat, input int lo, input int hi);
    wait_start();
    for (int k = 1; k <= lat; k++) begin
      step();
      if (k >= lo && k <= hi) frame_tick = 1'b1;
      if (k == lat) tx_done = 1'b1;
    end
  endtask

  task automatic serve_bytes(input int first, input int last);
    for (int b = first; b <= last; b++) serve_byte(20, 0, -1);
  endtask

  task automatic check_seen(input string nm);
    check({nm, "_len"}, seen.size(), 9);
    for (int i = 0; i < 9 && i < seen.size(); i++)
      check(nm, {24'd0, seen[i]}, {24'd0, gold[i]});
    $display("frame %s: %0d bytes, last %0h, overrun_cnt %0d", nm, seen.size(),
             (seen.size() > 0) ? seen[seen.size()-1] : 8'h00, overrun_cnt);
  endtask

  task automatic set_golden();
    xpos_tank = 10'h2A5; ypos_tank = 10'h1F0; direction_tank = 2'b10;
    tank_hit = 1'b1; obstacle_hit = 1'b0;
    xpos_bullet = 10'h000; ypos_bullet = 10'h3FF; direction_bullet = 3'b101; hp = 8'h64;
  endtask

  task automatic set_other();
    xpos_tank = 10'h15A; ypos_tank = 10'h20F; direction_tank = 2'b01;
    tank_hit = 1'b0; obstacle_hit = 1'b1;
    xpos_bullet = 10'h3C3; ypos_bullet = 10'h001; direction_bullet = 3'b010; hp = 8'h07;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    gold = '{8'hA5, 8'hA5, 8'hF0, 8'h9A, 8'h00, 8'hFF, 8'h35, 8'h64, 8'hC4};
    repeat (3) step();
    rst = 1'b0;
    chk_on = 1'b1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_tx_start", {31'd0, tx_start}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    check("rst_overrun", {24'd0, overrun_cnt}, 0);
    check("rst_frame_done", {31'd0, frame_done}, 0);

    // Golden frame with a latency pin on the header byte.
    link_en = 1'b1;
    set_golden();
    step();
    seen.delete();
    frame_tick = 1'b1;
    step();
    step();
    check("latency_start", {31'd0, tx_start}, 1);
    check("latency_header", {24'd0, tx_data}, 8'hA5);
    serve_bytes(0, 8);
    step();
    check("golden_frame_done", {31'd0, frame_done}, 1);
    check_seen("golden");

    // Snapshot: all inputs change the cycle after SNAP.
    step();
    seen.delete();
    frame_tick = 1'b1;
    step();
    step();
    set_other();
    serve_bytes(0, 8);
    step();
    check_seen("snapshot");
    set_golden();

    // Overrun: three mid-frame ticks plus one on the final tx_done.
    step();
    seen.delete();
    frame_tick = 1'b1;
    serve_byte(20, 0, -1);
    serve_byte(20, 3, 3);
    serve_byte(20, 0, -1);
    serve_byte(20, 5, 5);
    serve_byte(20, 0, -1);
    serve_byte(20, 7, 7);
    serve_bytes(6, 7);
    serve_byte(20, 20, 20);
    repeat (6) step();
    check("overrun_4", {24'd0, overrun_cnt}, 4);
    check("overrun_idle", {31'd0, busy}, 0);
    check_seen("overrun");

    // Saturation: 300 consecutive ticks while the header byte is outstanding.
    seen.delete();
    frame_tick = 1'b1;
    serve_byte(310, 1, 300);
    serve_bytes(1, 8);
    step();
    check("overrun_sat", {24'd0, overrun_cnt}, 8'hFF);
    check_seen("saturation");

    // Enable: a disabled tick is ignored; dropping link_en mid-frame does not abort.
    step();
    link_en = 1'b0;
    frame_tick = 1'b1;
    repeat (4) step();
    check("disabled_busy", {31'd0, busy}, 0);
    check("disabled_overrun", {24'd0, overrun_cnt}, 8'hFF);
    link_en = 1'b1;
    seen.delete();
    frame_tick = 1'b1;
    serve_bytes(0, 2);
    link_en = 1'b0;
    serve_bytes(3, 8);
    step();
    check("enable_frame_done", {31'd0, frame_done}, 1);
    check_seen("enable_drop");
    link_en = 1'b1;

    // Reset during the outstanding B4.
    step();
    frame_tick = 1'b1;
    serve_bytes(0, 3);
    wait_start();
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_tx_start", {31'd0, tx_start}, 0);
    check("midrst_overrun", {24'd0, overrun_cnt}, 0);
    check("midrst_tx_data", {24'd0, tx_data}, 0);
    repeat (3) step();
    seen.delete();
    frame_tick = 1'b1;
    step();
    step();
    check("postrst_start", {31'd0, tx_start}, 1);
    check("postrst_header", {24'd0, tx_data}, 8'hA5);
    link_en = 1'b0;
    serve_byte(20, 2, 4);
    link_en = 1'b1;
    serve_bytes(1, 8);
    step();
    check("postrst_overrun", {24'd0, overrun_cnt}, 0);
    check_seen("post_reset");

    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
